// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift array.
// Emits fully-interior windows as a packed 9-slot bus (slot j = 3*row + col).
module window_gen_3x3 #(
    parameter int unsigned PixelBit  = 8,
    parameter int unsigned ImgWidth  = 640,
    parameter int unsigned ImgHeight = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [PixelBit-1:0]   in_pixel,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [9*PixelBit-1:0] window
);

    localparam int unsigned XW   = (ImgWidth  > 1) ? $clog2(ImgWidth)  : 1;
    localparam int unsigned YW   = (ImgHeight > 1) ? $clog2(ImgHeight) : 1;
    localparam int unsigned WinW = 9 * PixelBit;

    logic [XW-1:0]       x_q, x_d, x_eff;
    logic [YW-1:0]       y_q, y_d, y_eff;
    logic [PixelBit-1:0] lb1 [ImgWidth];
    logic [PixelBit-1:0] lb2 [ImgWidth];
    logic [PixelBit-1:0] lb1_rd, lb2_rd;
    logic [PixelBit-1:0] sh_q [9];
    logic [PixelBit-1:0] sh_d [9];
    logic [WinW-1:0]     win_q, win_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                at_eol, at_eof;

    // in_sof overrides the counters so the pixel is always taken as (0,0)
    always_comb begin
        x_eff  = in_sof ? '0 : x_q;
        y_eff  = in_sof ? '0 : y_q;
        at_eol = (x_eff == XW'(ImgWidth - 1));
        at_eof = (y_eff == YW'(ImgHeight - 1));
        lb1_rd = lb1[x_eff];
        lb2_rd = lb2[x_eff];
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        sh_d    = sh_q;
        win_d   = win_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (in_valid) begin
            if (at_eol) begin
                x_d = '0;
                y_d = at_eof ? '0 : y_eff + YW'(1);
            end else begin
                x_d = x_eff + XW'(1);
                y_d = y_eff;
            end
            // shift one column left; new right column is {row y-2, row y-1, row y}
            sh_d[0] = sh_q[1]; sh_d[1] = sh_q[2]; sh_d[2] = lb2_rd;
            sh_d[3] = sh_q[4]; sh_d[4] = sh_q[5]; sh_d[5] = lb1_rd;
            sh_d[6] = sh_q[7]; sh_d[7] = sh_q[8]; sh_d[8] = in_pixel;
            if (x_eff >= XW'(2) && y_eff >= YW'(2)) begin
                valid_d = 1'b1;
                last_d  = at_eol && at_eof;
                for (int j = 0; j < 9; j++) begin
                    win_d[j*PixelBit +: PixelBit] = sh_d[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            for (int j = 0; j < 9; j++) begin
                sh_q[j] <= '0;
            end
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            sh_q    <= sh_d;
        end
    end

    // Line buffers: old contents are read combinationally above before this write lands
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb2[x_eff] <= lb1_rd;
            lb1[x_eff] <= in_pixel;
        end
    end

    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign window    = win_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3 on a 4x4 image: a reference frame model
// pushes expected windows (with their due cycle) as pixels are driven.
module tb_window_gen_3x3;

    localparam int unsigned PB = 8;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;

    typedef struct {
        logic [9*PB-1:0] win;
        logic            last;
        int              cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_sof = 1'b0;
    logic [PB-1:0]   in_pixel = '0;
    logic            out_valid;
    logic            out_last;
    logic [9*PB-1:0] window;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    logic prev_v = 1'b0;

    exp_t            exp_q [$];
    logic [9*PB-1:0] got_q [$];
    logic [PB-1:0]   pix [H][W];
    int mx = 0;
    int my = 0;

    window_gen_3x3 #(.PixelBit(PB), .ImgWidth(W), .ImgHeight(H)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_pixel (in_pixel),
        .out_valid(out_valid),
        .out_last (out_last),
        .window   (window)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        prev_v <= in_valid;
    end

    task automatic check(input string tag, input logic [9*PB-1:0] got, input logic [9*PB-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [PB-1:0] median9(input logic [9*PB-1:0] w);
        logic [PB-1:0] s [9];
        logic [PB-1:0] t;
        for (int i = 0; i < 9; i++) s[i] = w[i*PB +: PB];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
        return s[4];
    endfunction

    // Drive one beat and advance the reference model
    task automatic beat(input logic v, input logic sof, input logic [PB-1:0] p);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        in_sof   = sof;
        in_pixel = p;
        if (v) begin
            if (sof) begin mx = 0; my = 0; end
            pix[my][mx] = p;
            if (mx >= 2 && my >= 2) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        e.win[(3*r+c)*PB +: PB] = pix[my-2+r][mx-2+c];
                e.last = (mx == W-1) && (my == H-1);
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
            end
            if (mx == W-1) begin
                mx = 0;
                my = (my == H-1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, '0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (!prev_v) check("valid_after_idle", 72'(out_valid), 72'(0));
            if (!out_valid) check("last_without_valid", 72'(out_last), 72'(0));
            if (out_valid) begin
                got_q.push_back(window);
                if (exp_q.size() == 0) begin
                    check("spurious_window", 72'(out_valid), 72'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("window", window, e.win);
                    check("out_last", 72'(out_last), 72'(e.last));
                    check("window_cycle", 72'(cyc), 72'(e.cyc));
                end
            end
        end
    end

    task automatic end_test(input string tag, input int n_win);
        idle(3);
        check({tag, "_count"}, 72'(got_q.size()), 72'(n_win));
        check({tag, "_pending"}, 72'(exp_q.size()), 72'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got %0d expected 0", 1);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        check("reset_valid", 72'(out_valid), 72'(0));
        check("reset_last", 72'(out_last), 72'(0));
        check("reset_window", window, 72'(0));
        #1 rst_n = 1'b1;

        // Test 1: continuous 4x4 frame, value = 4y+x
        got_q.delete();
        for (int k = 0; k < 16; k++) beat(1'b1, k == 0, PB'(k));
        end_test("t1", 4);
        check("t1_first", got_q[0], 72'h0A_09_08_06_05_04_02_01_00);
        check("t1_last", got_q[3], 72'h0F_0E_0D_0B_0A_09_07_06_05);

        // Test 2: same frame with idle beats interleaved
        got_q.delete();
        for (int k = 0; k < 16; k++) begin
            beat(1'b1, k == 0, PB'(k));
            beat(1'b0, 1'b0, PB'($urandom_range(255)));
        end
        end_test("t2", 4);
        check("t2_first", got_q[0], 72'h0A_09_08_06_05_04_02_01_00);

        // Test 3: two back-to-back frames, second one via implicit wrap
        got_q.delete();
        for (int k = 0; k < 32; k++) beat(1'b1, k == 0, PB'(k));
        end_test("t3", 8);
        check("t3_win5", got_q[4], 72'h1A_19_18_16_15_14_12_11_10);

        // Test 4: in_sof reasserted at pixel 7 aborts the frame
        got_q.delete();
        for (int k = 0; k < 7; k++) beat(1'b1, k == 0, PB'(k));
        for (int k = 0; k < 16; k++) beat(1'b1, k == 0, PB'(100 + k));
        end_test("t4", 4);
        check("t4_first", got_q[0], 72'h6E_6D_6C_6A_69_68_66_65_64);

        // Test 5: reset mid-frame, then a frame without in_sof
        got_q.delete();
        for (int k = 0; k < 10; k++) beat(1'b1, k == 0, PB'(k));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_valid", 72'(out_valid), 72'(0));
        check("rst_last", 72'(out_last), 72'(0));
        check("rst_window", window, 72'(0));
        mx = 0; my = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 16; k++) beat(1'b1, 1'b0, PB'(k));
        end_test("t5", 4);
        check("t5_first", got_q[0], 72'h0A_09_08_06_05_04_02_01_00);
        check("t5_last", got_q[3], 72'h0F_0E_0D_0B_0A_09_07_06_05);

        // Test 6: all-ones frame, every window and its median must be all ones
        got_q.delete();
        for (int k = 0; k < 16; k++) beat(1'b1, k == 0, 8'hFF);
        end_test("t6", 4);
        foreach (got_q[i]) begin
            check("t6_ones", got_q[i], {9*PB{1'b1}});
            check("t6_median", 72'(median9(got_q[i])), 72'(8'hFF));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
